// File: rtl/video_stream_splitter_if.sv
// Avalon-ST video beat bundle shared by the splitter's input and both outputs.
// A beat transfers on a rising clk edge where valid & ready are both high; the source
// holds data/sop/eop/empty stable while valid is high and ready is low.
interface video_stream_splitter_if #(
    parameter int DW = 30,
    parameter int EW = 2
);
    logic [DW-1:0] data;
    logic          startofpacket;
    logic          endofpacket;
    logic [EW-1:0] empty;
    logic          valid;
    logic          ready;

    modport master (
        output data, startofpacket, endofpacket, empty, valid,
        input  ready
    );

    modport slave (
        input  data, startofpacket, endofpacket, empty, valid,
        output ready
    );
endinterface

// File: rtl/video_stream_splitter.sv
// Forks one Avalon-ST video stream to two sinks through 2-entry per-branch skid FIFOs,
// with a branch enable mask latched on each accepted start-of-packet beat.
module video_stream_splitter #(
    parameter int DW = 30,
    parameter int EW = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     branch_enable,
    video_stream_splitter_if.slave         stream_in,
    video_stream_splitter_if.master        stream_out_0,
    video_stream_splitter_if.master        stream_out_1,
    output logic                           o_dbg_state,
    output logic [1:0]                     o_dbg_mask
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_mask;
    logic [1:0] w_mask_nxt;

    beat_t      r_mem [2][2];
    logic [1:0] r_rd_ptr;
    logic [1:0] r_wr_ptr;
    logic [1:0] r_count [2];

    beat_t      w_in_beat;
    beat_t      w_head [2];
    logic [1:0] w_push_mask;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_out_valid;
    logic [1:0] w_out_ready;
    logic       w_in_ready;
    logic       w_accept;

    // A SOP beat always uses the live enables; a stray non-SOP beat in IDLE goes nowhere.
    always_comb begin
        w_push_mask = 2'b00;
        if (stream_in.startofpacket) begin
            w_push_mask = branch_enable;
        end else if (r_state == ST_PKT) begin
            w_push_mask = r_mask;
        end
    end

    // Ready only looks at FIFO occupancy, never at the downstream ready inputs.
    always_comb begin
        w_in_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            if (w_push_mask[b] && (r_count[b] == 2'd2)) begin
                w_in_ready = 1'b0;
            end
        end
    end

    always_comb begin
        w_in_beat = {stream_in.data, stream_in.startofpacket,
                     stream_in.endofpacket, stream_in.empty};
        w_accept  = stream_in.valid & w_in_ready;
        w_push    = w_accept ? w_push_mask : 2'b00;
        w_out_ready = {stream_out_1.ready, stream_out_0.ready};
        for (int b = 0; b < 2; b++) begin
            w_out_valid[b] = (r_count[b] != 2'd0);
            w_head[b]      = r_mem[b][r_rd_ptr[b]];
        end
        w_pop = w_out_valid & w_out_ready;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        if (w_accept) begin
            if (stream_in.startofpacket) begin
                w_mask_nxt  = branch_enable;
                w_state_nxt = stream_in.endofpacket ? ST_IDLE : ST_PKT;
            end else if ((r_state == ST_PKT) && stream_in.endofpacket) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_mask  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= 2'b00;
            r_wr_ptr <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                r_count[b] <= 2'd0;
                for (int e = 0; e < 2; e++) begin
                    r_mem[b][e] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_push[b]) begin
                    r_mem[b][r_wr_ptr[b]] <= w_in_beat;
                    r_wr_ptr[b]           <= ~r_wr_ptr[b];
                end
                if (w_pop[b]) begin
                    r_rd_ptr[b] <= ~r_rd_ptr[b];
                end
                case ({w_push[b], w_pop[b]})
                    2'b10:   r_count[b] <= r_count[b] + 2'd1;
                    2'b01:   r_count[b] <= r_count[b] - 2'd1;
                    default: r_count[b] <= r_count[b];
                endcase
            end
        end
    end

    assign stream_in.ready = w_in_ready;

    assign stream_out_0.data          = w_head[0].data;
    assign stream_out_0.startofpacket = w_head[0].sop;
    assign stream_out_0.endofpacket   = w_head[0].eop;
    assign stream_out_0.empty         = w_head[0].empty;
    assign stream_out_0.valid         = w_out_valid[0];

    assign stream_out_1.data          = w_head[1].data;
    assign stream_out_1.startofpacket = w_head[1].sop;
    assign stream_out_1.endofpacket   = w_head[1].eop;
    assign stream_out_1.empty         = w_head[1].empty;
    assign stream_out_1.valid         = w_out_valid[1];

    assign o_dbg_state = r_state;
    assign o_dbg_mask  = r_mask;

endmodule

// File: tb/tb_video_stream_splitter.sv
// Directed bench for video_stream_splitter: per-cycle vector table with hand-computed
// expectations, plus hand-written reset sequences.
module tb_video_stream_splitter;
    localparam int DW = 30;
    localparam int EW = 2;
    localparam int BW = DW + 2 + EW;
    localparam logic [BW-1:0] NB = '0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] en;
    logic       dbg_state;
    logic [1:0] dbg_mask;

    video_stream_splitter_if #(.DW(DW), .EW(EW)) in_if ();
    video_stream_splitter_if #(.DW(DW), .EW(EW)) out0_if ();
    video_stream_splitter_if #(.DW(DW), .EW(EW)) out1_if ();

    video_stream_splitter #(.DW(DW), .EW(EW)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .branch_enable (en),
        .stream_in     (in_if),
        .stream_out_0  (out0_if),
        .stream_out_1  (out1_if),
        .o_dbg_state   (dbg_state),
        .o_dbg_mask    (dbg_mask)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    en;
        logic          vld;
        logic          sop;
        logic          eop;
        logic [DW-1:0] d;
        logic [EW-1:0] m;
        logic          r0;
        logic          r1;
        logic          x_rdy;
        logic          x_v0;
        logic [BW-1:0] x_b0;
        logic          x_v1;
        logic [BW-1:0] x_b1;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [BW-1:0] mkb(input logic [DW-1:0] d, input logic s,
                                          input logic e, input logic [EW-1:0] m);
        return {d, s, e, m};
    endfunction

    function automatic vec_t mkv(input logic [1:0] e, input logic vld, input logic sop,
                                 input logic eop, input logic [DW-1:0] d, input logic [EW-1:0] m,
                                 input logic r0, input logic r1, input logic x_rdy,
                                 input logic x_v0, input logic [BW-1:0] x_b0,
                                 input logic x_v1, input logic [BW-1:0] x_b1);
        vec_t v;
        v.en = e; v.vld = vld; v.sop = sop; v.eop = eop; v.d = d; v.m = m;
        v.r0 = r0; v.r1 = r1; v.x_rdy = x_rdy;
        v.x_v0 = x_v0; v.x_b0 = x_b0; v.x_v1 = x_v1; v.x_b1 = x_b1;
        return v;
    endfunction

    // scoreboard compare
    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] out0_beat();
        return {out0_if.data, out0_if.startofpacket, out0_if.endofpacket, out0_if.empty};
    endfunction

    function automatic logic [BW-1:0] out1_beat();
        return {out1_if.data, out1_if.startofpacket, out1_if.endofpacket, out1_if.empty};
    endfunction

    // drivers
    task automatic drive(input vec_t v);
        en                  = v.en;
        in_if.valid         = v.vld;
        in_if.startofpacket = v.sop;
        in_if.endofpacket   = v.eop;
        in_if.data          = v.d;
        in_if.empty         = v.m;
        out0_if.ready       = v.r0;
        out1_if.ready       = v.r1;
    endtask

    task automatic check_vec(input vec_t v);
        chk("in_ready", in_if.ready, v.x_rdy);
        chk("out0_valid", out0_if.valid, v.x_v0);
        chk("out1_valid", out1_if.valid, v.x_v1);
        if (v.x_v0) chk("out0_beat", out0_beat(), v.x_b0);
        if (v.x_v1) chk("out1_beat", out1_beat(), v.x_b1);
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        #2;
        check_vec(v);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input vec_t v);
        vecs.push_back(v);
    endtask

    initial begin
        // reset state
        drive(mkv(2'b00, 0, 0, 0, '0, '0, 0, 0, 0, 0, NB, 0, NB));
        #3;
        chk("rst_in_ready", in_if.ready, 1'b1);
        chk("rst_out0_valid", out0_if.valid, 1'b0);
        chk("rst_out1_valid", out1_if.valid, 1'b0);
        chk("rst_out0_beat", out0_beat(), NB);
        chk("rst_out1_beat", out1_beat(), NB);
        chk("rst_state", dbg_state, 1'b0);
        chk("rst_mask", dbg_mask, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // both branches, 4-beat packet, full throughput
        add(mkv(2'b11, 0, 0, 0, 30'h0,        0, 1, 1, 1, 0, NB, 0, NB));
        add(mkv(2'b11, 1, 1, 0, 30'h1,        0, 1, 1, 1, 0, NB, 0, NB));
        add(mkv(2'b11, 1, 0, 0, 30'h2,        0, 1, 1, 1, 1, mkb(30'h1, 1, 0, 0), 1, mkb(30'h1, 1, 0, 0)));
        add(mkv(2'b11, 1, 0, 0, 30'h3,        0, 1, 1, 1, 1, mkb(30'h2, 0, 0, 0), 1, mkb(30'h2, 0, 0, 0)));
        add(mkv(2'b11, 1, 0, 1, 30'h3FFFFFFF, 2, 1, 1, 1, 1, mkb(30'h3, 0, 0, 0), 1, mkb(30'h3, 0, 0, 0)));
        add(mkv(2'b11, 0, 0, 0, 30'h0,        0, 1, 1, 1, 1, mkb(30'h3FFFFFFF, 0, 1, 2), 1, mkb(30'h3FFFFFFF, 0, 1, 2)));
        add(mkv(2'b11, 0, 0, 0, 30'h0,        0, 1, 1, 1, 0, NB, 0, NB));

        // out_1 stalled: backpressure after 2 beats, then drain in order
        add(mkv(2'b11, 1, 1, 0, 30'h10, 0, 1, 0, 1, 0, NB, 0, NB));
        add(mkv(2'b11, 1, 0, 0, 30'h11, 0, 1, 0, 1, 1, mkb(30'h10, 1, 0, 0), 1, mkb(30'h10, 1, 0, 0)));
        add(mkv(2'b11, 1, 0, 0, 30'h12, 0, 1, 0, 0, 1, mkb(30'h11, 0, 0, 0), 1, mkb(30'h10, 1, 0, 0)));
        add(mkv(2'b11, 1, 0, 0, 30'h12, 0, 1, 0, 0, 0, NB, 1, mkb(30'h10, 1, 0, 0)));
        add(mkv(2'b11, 1, 0, 0, 30'h12, 0, 1, 1, 0, 0, NB, 1, mkb(30'h10, 1, 0, 0)));
        add(mkv(2'b11, 1, 0, 0, 30'h12, 0, 1, 1, 1, 0, NB, 1, mkb(30'h11, 0, 0, 0)));
        add(mkv(2'b11, 1, 0, 0, 30'h13, 0, 1, 1, 1, 1, mkb(30'h12, 0, 0, 0), 1, mkb(30'h12, 0, 0, 0)));
        add(mkv(2'b11, 1, 0, 0, 30'h14, 0, 1, 1, 1, 1, mkb(30'h13, 0, 0, 0), 1, mkb(30'h13, 0, 0, 0)));
        add(mkv(2'b11, 1, 0, 1, 30'h15, 1, 1, 1, 1, 1, mkb(30'h14, 0, 0, 0), 1, mkb(30'h14, 0, 0, 0)));
        add(mkv(2'b11, 0, 0, 0, 30'h0,  0, 1, 1, 1, 1, mkb(30'h15, 0, 1, 1), 1, mkb(30'h15, 0, 1, 1)));
        add(mkv(2'b11, 0, 0, 0, 30'h0,  0, 1, 1, 1, 0, NB, 0, NB));

        // mask latched at SOP: mid-packet enable change ignored, next packet uses it
        add(mkv(2'b01, 1, 1, 0, 30'h20, 0, 1, 1, 1, 0, NB, 0, NB));
        add(mkv(2'b11, 1, 0, 0, 30'h21, 0, 1, 1, 1, 1, mkb(30'h20, 1, 0, 0), 0, NB));
        add(mkv(2'b11, 1, 0, 0, 30'h22, 0, 1, 1, 1, 1, mkb(30'h21, 0, 0, 0), 0, NB));
        add(mkv(2'b11, 1, 0, 1, 30'h23, 0, 1, 1, 1, 1, mkb(30'h22, 0, 0, 0), 0, NB));
        add(mkv(2'b11, 1, 1, 0, 30'h30, 0, 1, 1, 1, 1, mkb(30'h23, 0, 1, 0), 0, NB));
        add(mkv(2'b11, 1, 0, 1, 30'h31, 3, 1, 1, 1, 1, mkb(30'h30, 1, 0, 0), 1, mkb(30'h30, 1, 0, 0)));
        add(mkv(2'b11, 0, 0, 0, 30'h0,  0, 1, 1, 1, 1, mkb(30'h31, 0, 1, 3), 1, mkb(30'h31, 0, 1, 3)));
        add(mkv(2'b11, 0, 0, 0, 30'h0,  0, 1, 1, 1, 0, NB, 0, NB));

        // both disabled: whole packet drained, nothing emitted
        add(mkv(2'b00, 1, 1, 0, 30'h40, 0, 1, 1, 1, 0, NB, 0, NB));
        add(mkv(2'b00, 1, 0, 0, 30'h41, 0, 1, 1, 1, 0, NB, 0, NB));
        add(mkv(2'b00, 1, 0, 1, 30'h42, 0, 1, 1, 1, 0, NB, 0, NB));
        add(mkv(2'b00, 0, 0, 0, 30'h0,  0, 1, 1, 1, 0, NB, 0, NB));

        // non-SOP beats in IDLE are discarded, then a 2-beat packet
        add(mkv(2'b11, 1, 0, 0, 30'h50, 0, 1, 1, 1, 0, NB, 0, NB));
        add(mkv(2'b11, 1, 0, 0, 30'h51, 0, 1, 1, 1, 0, NB, 0, NB));
        add(mkv(2'b11, 1, 0, 1, 30'h52, 0, 1, 1, 1, 0, NB, 0, NB));
        add(mkv(2'b11, 1, 1, 0, 30'h60, 0, 1, 1, 1, 0, NB, 0, NB));
        add(mkv(2'b11, 1, 0, 1, 30'h61, 0, 1, 1, 1, 1, mkb(30'h60, 1, 0, 0), 1, mkb(30'h60, 1, 0, 0)));
        add(mkv(2'b11, 0, 0, 0, 30'h0,  0, 1, 1, 1, 1, mkb(30'h61, 0, 1, 0), 1, mkb(30'h61, 0, 1, 0)));
        add(mkv(2'b11, 0, 0, 0, 30'h0,  0, 1, 1, 1, 0, NB, 0, NB));

        foreach (vecs[i]) apply(vecs[i]);
        chk("idle_after_table", dbg_state, 1'b0);

        // reset mid-packet with both FIFOs full
        apply(mkv(2'b11, 1, 1, 0, 30'h70, 0, 0, 0, 1, 0, NB, 0, NB));
        apply(mkv(2'b11, 1, 0, 0, 30'h71, 0, 0, 0, 1, 1, mkb(30'h70, 1, 0, 0), 1, mkb(30'h70, 1, 0, 0)));
        drive(mkv(2'b11, 1, 0, 0, 30'h72, 0, 0, 0, 0, 0, NB, 0, NB));
        #2;
        chk("full_in_ready", in_if.ready, 1'b0);
        chk("full_out0_valid", out0_if.valid, 1'b1);
        chk("full_out1_valid", out1_if.valid, 1'b1);
        chk("pkt_state", dbg_state, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_out0_valid", out0_if.valid, 1'b0);
        chk("arst_out1_valid", out1_if.valid, 1'b0);
        chk("arst_out0_beat", out0_beat(), NB);
        chk("arst_out1_beat", out1_beat(), NB);
        chk("arst_state", dbg_state, 1'b0);
        chk("arst_mask", dbg_mask, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mkv(2'b11, 1, 0, 0, 30'h73, 0, 1, 1, 1, 0, NB, 0, NB));
        apply(mkv(2'b11, 1, 0, 0, 30'h74, 0, 1, 1, 1, 0, NB, 0, NB));
        apply(mkv(2'b11, 1, 1, 0, 30'h80, 0, 1, 1, 1, 0, NB, 0, NB));
        apply(mkv(2'b11, 1, 0, 1, 30'h81, 2, 1, 1, 1, 1, mkb(30'h80, 1, 0, 0), 1, mkb(30'h80, 1, 0, 0)));
        apply(mkv(2'b11, 0, 0, 0, 30'h0,  0, 1, 1, 1, 1, mkb(30'h81, 0, 1, 2), 1, mkb(30'h81, 0, 1, 2)));
        apply(mkv(2'b11, 0, 0, 0, 30'h0,  0, 1, 1, 1, 0, NB, 0, NB));
        chk("final_state", dbg_state, 1'b0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
